// File: rtl/peak_window_ctrl_if.sv
// rtl/peak_window_ctrl_if.sv - sample stream and window result port bundle for peak_window_ctrl
interface peak_window_ctrl_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]     s_axis_tdata;
    logic                      s_axis_tvalid;
    logic                      s_axis_tlast;
    logic                      s_axis_tready;
    logic                      m_res_valid;
    logic                      m_res_ready;
    logic [4*SAMPLE_WIDTH-1:0] m_res_max;
    logic [1:0]                m_res_chan;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_res_ready,
        input  s_axis_tready, m_res_valid, m_res_max, m_res_chan
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_res_ready,
        output s_axis_tready, m_res_valid, m_res_max, m_res_chan
    );
endinterface

// File: rtl/peak_window_ctrl.sv
// rtl/peak_window_ctrl.sv - per-window 4-channel peak tracker on a two-beat frame stream
// Optional magnitude mode selected by defining PEAK_ABS_EN.
module peak_window_ctrl #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int WINDOW_FRAMES        = 500
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_areset,
    peak_window_ctrl_if.slave bus,
    input  logic              arm,
    input  logic              continuous,
    input  logic              abort,
    output logic              busy,
    output logic              err_misalign
);
    localparam int SW = SAMPLE_WIDTH;
    localparam logic [23:0] LAST_CNT = 24'(WINDOW_FRAMES);
`ifdef PEAK_ABS_EN
    localparam logic signed [SW-1:0] ACC_INIT = '0;
`else
    localparam logic signed [SW-1:0] ACC_INIT = {1'b1, {(SW-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, SYNC, ACCUM, REPORT} state_t;

    function automatic logic signed [SW-1:0] cond(input logic signed [SW-1:0] x);
`ifdef PEAK_ABS_EN
        // The most negative code has no positive twin, so it saturates.
        if (x == {1'b1, {(SW-1){1'b0}}})
            cond = {1'b0, {(SW-1){1'b1}}};
        else if (x < 0)
            cond = -x;
        else
            cond = x;
`else
        cond = x;
`endif
    endfunction

    state_t                  state;
    logic                    phase;       // 0 = expecting beat A, 1 = expecting beat B
    logic                    rdy_q;
    logic [23:0]             frame_cnt;
    logic signed [SW-1:0]    acc [4];

    logic                    beat, beat_a, beat_b, bad_last, bad_first, phase_next;
    logic                    handshake, clear_win;
    logic [23:0]             cnt_inc;
    logic signed [SW-1:0]    lo, hi, best_val;
    logic [1:0]              best_chan;

    assign bus.s_axis_tready = rdy_q && (state != REPORT);
    assign busy              = (state != IDLE);

    assign beat      = bus.s_axis_tvalid && bus.s_axis_tready;
    assign beat_a    = beat && !bus.s_axis_tlast;
    assign beat_b    = beat && bus.s_axis_tlast && phase;
    assign bad_last  = beat && bus.s_axis_tlast && !phase;
    assign bad_first = beat && !bus.s_axis_tlast && phase;
    assign phase_next = beat_a ? 1'b1 : (beat_b ? 1'b0 : phase);

    assign lo      = cond(bus.s_axis_tdata[SW-1:0]);
    assign hi      = cond(bus.s_axis_tdata[C_S_AXIS_TDATA_WIDTH-1:SW]);
    assign cnt_inc = frame_cnt + 24'd1;

    assign handshake = (state == REPORT) && bus.m_res_valid && bus.m_res_ready;
    assign clear_win = handshake || (abort && state != IDLE);

    // Strict greater-than scan keeps the lowest index on ties.
    always_comb begin
        best_chan = 2'd0;
        best_val  = acc[0];
        for (int i = 1; i < 4; i++) begin
            if (acc[i] > best_val) begin
                best_val  = acc[i];
                best_chan = 2'(i);
            end
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state           <= IDLE;
            phase           <= 1'b0;
            rdy_q           <= 1'b0;
            frame_cnt       <= '0;
            for (int i = 0; i < 4; i++) acc[i] <= ACC_INIT;
            bus.m_res_valid <= 1'b0;
            bus.m_res_max   <= '0;
            bus.m_res_chan  <= 2'd0;
            err_misalign    <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            phase <= phase_next;

            if (bad_last || bad_first)
                err_misalign <= 1'b1;
            else if (arm && !abort && state == IDLE)
                err_misalign <= 1'b0;

            if (clear_win) begin
                frame_cnt <= '0;
                for (int i = 0; i < 4; i++) acc[i] <= ACC_INIT;
            end else if (state == ACCUM) begin
                if (beat_a) begin
                    if (lo > acc[0]) acc[0] <= lo;
                    if (hi > acc[1]) acc[1] <= hi;
                end
                if (beat_b) begin
                    if (lo > acc[2]) acc[2] <= lo;
                    if (hi > acc[3]) acc[3] <= hi;
                    frame_cnt <= cnt_inc;
                end
            end

            case (state)
                IDLE: begin
                    // Skip SYNC when this cycle already leaves us at a frame boundary.
                    if (arm && !abort)
                        state <= phase_next ? SYNC : ACCUM;
                end
                SYNC: begin
                    if (abort)
                        state <= IDLE;
                    else if (beat && bus.s_axis_tlast)
                        state <= ACCUM;
                end
                ACCUM: begin
                    if (abort)
                        state <= IDLE;
                    else if (beat_b && cnt_inc == LAST_CNT)
                        state <= REPORT;
                end
                REPORT: begin
                    if (handshake) begin
                        bus.m_res_valid <= 1'b0;
                        state <= (continuous && !abort) ? ACCUM : IDLE;
                    end else if (abort) begin
                        bus.m_res_valid <= 1'b0;
                        state <= IDLE;
                    end else if (!bus.m_res_valid) begin
                        bus.m_res_max   <= {acc[3], acc[2], acc[1], acc[0]};
                        bus.m_res_chan  <= best_chan;
                        bus.m_res_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
